// File: rtl/serial_bus_arbiter_if.sv
// Bundle of request, frame-field and bus-side signals between the node
// transmitters (master) and the serial bus arbiter (slave).
interface serial_bus_arbiter_if #(
    parameter int NODES  = 16,
    parameter int DATA_W = 64
);
    logic [NODES-1:0]        req;
    logic [3:0]              mod;
    logic [4*NODES-1:0]      addr_flat;
    logic [DATA_W*NODES-1:0] data_flat;
    logic [4*NODES-1:0]      crc_flat;
    logic [NODES-1:0]        grant;
    logic [NODES-1:0]        ack;
    logic                    busy;
    logic                    bus_out;

    modport master (
        output req, mod, addr_flat, data_flat, crc_flat,
        input  grant, ack, busy, bus_out
    );

    modport slave (
        input  req, mod, addr_flat, data_flat, crc_flat,
        output grant, ack, busy, bus_out
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Grants the shared serial line to one of NODES requesters (round-robin or
// fixed priority) and shifts the winner's 77-bit frame out MSB-first.
//
// state | meaning
// IDLE  | line at 1, no owner; a nonzero req captures a winner
// SEND  | frame bits shifted out, one per cycle, 77 cycles
// STOP  | line at 1, ack pulses for the owner, then back to IDLE
module serial_bus_arbiter #(
    parameter int NODES  = 16,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    serial_bus_arbiter_if.slave bus
);

    localparam int         IDX_W    = $clog2(NODES);
    localparam int         FRAME_W  = 1 + IDX_W + 4 + DATA_W + 4;
    localparam logic [6:0] LAST_BIT = 7'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame_nxt;
    logic [6:0]         bit_cnt;
    logic [NODES-1:0]   grant_q;
    logic [NODES-1:0]   ack_q;
    logic               unused_mod;

    assign unused_mod = ^bus.mod[3:1];

    // Scan order starts at ptr for round-robin, at 0 for fixed priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NODES; i++) begin
            cand = bus.mod[0] ? IDX_W'(i) : ptr + IDX_W'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign frame_nxt = {1'b0,
                        win_idx,
                        bus.addr_flat[int'(win_idx)*4 +: 4],
                        bus.data_flat[int'(win_idx)*DATA_W +: DATA_W],
                        bus.crc_flat[int'(win_idx)*4 +: 4]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.bus_out = 1'b1;
        bus.busy    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) state_nxt = SEND;
            end
            SEND: begin
                bus.bus_out = shreg[FRAME_W-1];
                bus.busy    = 1'b1;
                if (bit_cnt == LAST_BIT) state_nxt = STOP;
            end
            STOP: begin
                bus.busy  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            grant_q <= '0;
            ack_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_q <= NODES'(1) << win_idx;
                        shreg   <= frame_nxt;
                        bit_cnt <= '0;
                        if (!bus.mod[0]) ptr <= win_idx + 1'b1;
                    end
                end
                SEND: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) ack_q <= grant_q;
                end
                STOP: begin
                    grant_q <= '0;
                    ack_q   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: a transaction-level model checked
// every cycle, plus literal expectations on grant order, timing and frame bits.
module tb_serial_bus_arbiter;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    serial_bus_arbiter_if bus ();

    serial_bus_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [15:0] last_grant = '0;
    logic        rise       = 1'b0;
    logic [15:0] pend       = '0;
    logic        reassert   = 1'b0;

    // Model: one frame is "active" for 78 cycles after capture (77 bits + stop).
    logic        m_active = 1'b0;
    int          m_t      = 0;
    int          mptr     = 0;
    logic [15:0] m_grant  = '0;
    logic [76:0] m_frame  = '0;

    function automatic int pick(input logic [15:0] r, input logic fp, input int p);
        int j;
        for (int i = 0; i < 16; i++) begin
            j = fp ? i : (p + i) % 16;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [76:0] build_frame(input int w);
        return {1'b0, 4'(w), bus.addr_flat[4*w +: 4], bus.data_flat[64*w +: 64],
                bus.crc_flat[4*w +: 4]};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            mptr     <= 0;
            m_grant  <= '0;
        end else if (m_active) begin
            m_t <= m_t + 1;
            if (m_t == 77) begin
                m_active <= 1'b0;
                m_grant  <= '0;
            end
        end else if (bus.req != 16'h0) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_grant  <= 16'h1 << pick(bus.req, bus.mod[0], mptr);
            m_frame  <= build_frame(pick(bus.req, bus.mod[0], mptr));
            if (!bus.mod[0]) mptr <= (pick(bus.req, 1'b0, mptr) + 1) % 16;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        logic        e_bus;
        logic [15:0] e_ack;
        e_bus = (m_active && m_t <= 76) ? m_frame[76 - m_t] : 1'b1;
        e_ack = (m_active && m_t == 77) ? m_grant : 16'h0;
        chk("model_bus_out", bus.bus_out, e_bus);
        chk("model_grant", bus.grant, m_active ? m_grant : 16'h0);
        chk("model_ack", bus.ack, e_ack);
        chk("model_busy", bus.busy, m_active);
    end

    // Advance to the next falling edge; owners drop req on ack and optionally reassert.
    task automatic tick();
        @(negedge clock);
        cyc++;
        rise       = (bus.grant != 16'h0) && (last_grant == 16'h0);
        last_grant = bus.grant;
        for (int i = 0; i < 16; i++) begin
            if (bus.ack[i]) begin
                bus.req[i] = 1'b0;
                pend[i]    = reassert;
            end else if (pend[i]) begin
                bus.req[i] = 1'b1;
                pend[i]    = 1'b0;
            end
        end
    endtask

    task automatic wait_grant(input string name, output logic [15:0] g, output int at);
        g  = '0;
        at = -1;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (rise) begin
                g  = bus.grant;
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: no grant within 200 cycles (cycle %0d)", name, cyc);
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 200; n++) begin
            tick();
            if (!bus.busy && bus.req == 16'h0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: not idle within 200 cycles (cycle %0d)", name, cyc);
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        pend    = '0;
    endtask

    logic [15:0] g;
    int          t0;
    int          prev;
    logic [76:0] rec;
    logic [76:0] exp_single;

    initial begin
        bus.req       = '0;
        bus.mod       = '0;
        bus.addr_flat = '0;
        bus.data_flat = '0;
        bus.crc_flat  = '0;
        #1 reset_n = 1'b0;

        // Reset idle
        repeat (3) tick();
        reset_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("idle_bus_out", bus.bus_out, 1'b1);
            chk("idle_grant", bus.grant, 16'h0);
            chk("idle_busy", bus.busy, 1'b0);
        end

        // Single frame from node 1
        bus.addr_flat[7:4]    = 4'h1;
        bus.data_flat[127:64] = 64'h1;
        bus.crc_flat[7:4]     = 4'h1;
        exp_single = {1'b0, 4'h1, 4'h1, 64'h1, 4'h1};
        bus.req = 16'h0002;
        wait_grant("single", g, t0);
        chk("single_grant", g, 16'h0002);
        rec[76] = bus.bus_out;
        for (int k = 1; k < 77; k++) begin
            tick();
            rec[76 - k] = bus.bus_out;
            chk("single_no_early_ack", bus.ack, 16'h0);
        end
        tick();
        chk("single_ack", bus.ack, 16'h0002);
        chk("single_ack_cycle", cyc - t0, 77);
        chk("single_stop_bus", bus.bus_out, 1'b1);
        chk("single_bits", rec, exp_single);
        tick();
        chk("single_ack_clear", bus.ack, 16'h0);
        chk("single_grant_clear", bus.grant, 16'h0);

        // Random frame contents from here on
        for (int i = 0; i < 32; i++) bus.data_flat[32*i +: 32] = $urandom;
        bus.addr_flat = {$urandom, $urandom};
        bus.crc_flat  = {$urandom, $urandom};

        // Round-robin over all 16 nodes
        do_reset();
        reassert = 1'b1;
        bus.mod  = 4'b1110;
        bus.req  = 16'hFFFF;
        prev     = 0;
        for (int k = 0; k < 17; k++) begin
            wait_grant("rr", g, t0);
            chk("rr_grant", g, 16'h1 << (k % 16));
            if (k > 0) chk("rr_spacing", t0 - prev, 79);
            prev = t0;
        end
        reassert = 1'b0;
        pend     = '0;
        bus.req  = 16'h0001;
        wait_idle("rr_end");

        // Fixed priority leaves ptr alone
        do_reset();
        bus.mod = 4'b1111;
        bus.req = 16'h8005;
        wait_grant("fp0", g, t0);
        chk("fp_first", g, 16'h0001);
        wait_grant("fp1", g, t0);
        chk("fp_second", g, 16'h0004);
        wait_grant("fp2", g, t0);
        chk("fp_third", g, 16'h8000);
        wait_idle("fp_end");
        bus.req = 16'h0002;
        wait_grant("fp3", g, t0);
        chk("fp_node1", g, 16'h0002);
        wait_idle("fp_end2");
        bus.mod = 4'b1110;
        bus.req = 16'h8003;
        wait_grant("ptr0", g, t0);
        chk("ptr_unchanged", g, 16'h0001);
        wait_grant("ptr1", g, t0);
        chk("ptr_next", g, 16'h0002);
        wait_grant("ptr2", g, t0);
        chk("ptr_last", g, 16'h8000);
        wait_idle("ptr_end");

        // Wrap from ptr=15 with mid-frame input churn
        bus.req = 16'h4000;
        wait_grant("pre_wrap", g, t0);
        chk("pre_wrap_grant", g, 16'h4000);
        wait_idle("pre_wrap_end");
        bus.req = 16'h8001;
        wait_grant("wrap", g, t0);
        chk("wrap_grant", g, 16'h8000);
        for (int n = 0; n < 60; n++) begin
            tick();
            bus.req                 = 16'($urandom);
            bus.mod                 = 4'($urandom);
            bus.data_flat[1023:960] = {$urandom, $urandom};
            bus.crc_flat[63:60]     = 4'($urandom);
        end
        bus.req = 16'h8001;
        bus.mod = 4'b0000;
        wait_grant("after_wrap", g, t0);
        chk("after_wrap_grant", g, 16'h0001);
        wait_idle("wrap_end");

        // Reset in the middle of a frame
        bus.req = 16'h0004;
        wait_grant("mid", g, t0);
        chk("mid_grant", g, 16'h0004);
        repeat (30) tick();
        bus.req = 16'h0006;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_reset_bus_out", bus.bus_out, 1'b1);
        chk("mid_reset_grant", bus.grant, 16'h0);
        chk("mid_reset_ack", bus.ack, 16'h0);
        chk("mid_reset_busy", bus.busy, 1'b0);
        repeat (3) tick();
        reset_n = 1'b1;
        wait_grant("restart", g, t0);
        chk("restart_ptr0", g, 16'h0002);
        wait_grant("restart2", g, t0);
        chk("restart_second", g, 16'h0004);
        wait_idle("final");

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
